sseg_mux: RTL and testbench
===========================

SSEG_MUX -- requirements
Module: sseg_mux

Interface
REQ-001 SHALL provide parameter REFRESH_MAX, default 49999, last slot-counter value per digit (slot length REFRESH_MAX+1 cycles), legal range 1..2^24-1.
REQ-002 SHALL provide parameter BLANK_CYCLES, default 1000, cycles of anode blanking at the start of each slot, legal range 0..REFRESH_MAX.
REQ-003 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port en  input  1  scan enable, active-high.
REQ-006 SHALL have ports dig_0, dig_1, dig_2, dig_3  input  8 each  digit segment patterns, active-low, bit 7 = dp.
REQ-007 SHALL have port an  output  4  digit anode selects, active-low, an[i] drives digit i.
REQ-008 SHALL have port sseg  output  8  segment drive, active-low, same bit order as dig_*.
REQ-009 SHALL have port frame_start  output  1  one-cycle pulse marking digit-0 slot start.

Function
REQ-010 SHALL keep a 24-bit slot counter that counts 0..REFRESH_MAX and wraps to 0 at REFRESH_MAX.
REQ-011 SHALL keep a 2-bit digit index that increments mod 4 (3 wraps to 0) in the cycle the slot counter wraps.
REQ-012 SHALL hold four 8-bit shadow registers; sseg is sourced only from these, never directly from dig_*.
REQ-013 With en=1, SHALL load all four shadow registers from dig_0..dig_3 only in the cycle slot counter = REFRESH_MAX and index = 3 (frame boundary), giving tear-free whole-frame updates.
REQ-014 With en=0, SHALL load shadow registers from dig_* every cycle.
REQ-015 SHALL register an, sseg and frame_start: outputs reflect counter/index state with exactly one cycle latency.
REQ-016 While slot counter < BLANK_CYCLES, SHALL drive an = 4'b1111 and sseg = 8'hFF (next cycle, per REQ-015).
REQ-017 While slot counter >= BLANK_CYCLES, SHALL drive an with only bit [index] low and sseg = shadow[index].
REQ-018 BLANK_CYCLES = 0 SHALL disable blanking entirely.
REQ-019 SHALL assert frame_start for one cycle, one cycle after slot counter = 0 with index = 0, including the first slot after reset or enable.
REQ-020 With en=0, SHALL hold slot counter and index at 0, drive an = 4'b1111, sseg = 8'hFF, frame_start = 0.
REQ-021 On en rising, SHALL start counting from slot 0, index 0, in the next cycle; frame_start follows per REQ-019.
REQ-022 en falling mid-slot SHALL abandon the frame, with outputs blank one cycle later and no partial-frame carry-over.
REQ-023 dig_* changes mid-frame SHALL NOT affect sseg until the next frame boundary load.

Reset
REQ-024 On reset_n low, SHALL immediately (asynchronously) set slot counter = 0, index = 0, all shadow registers = 8'hFF, an = 4'b1111, sseg = 8'hFF, frame_start = 0.
REQ-025 After reset_n deassertion with en=1, SHALL begin at slot 0, index 0 on the first clock edge; the first frame shows all-blank shadows (8'hFF) until the first frame boundary load.
REQ-026 Reset asserted mid-operation SHALL produce the REQ-024 state regardless of counter, index or en.

Verification (REFRESH_MAX=9, BLANK_CYCLES=2)
REQ-027 Reset released, en=1, dig_0..3 = C0,F9,A4,B0: frame_start pulses at cycle 1 and every 40 cycles; the first 40 cycles show sseg=FF; from the second frame, slot cycles 3..10 show an=1110/sseg=C0, then 1101/F9, 1011/A4, 0111/B0, and cycles 1..2 of each slot show an=1111.
REQ-028 dig_1 changes F9->92 mid-frame: the current frame still shows F9 in the digit-1 slot, and the next frame shows 92.
REQ-029 en dropped during the digit-2 slot: next cycle an=1111, sseg=FF, frame_start=0; en re-raised: frame_start pulses, digit 0 shows current dig_0 after 2 blank cycles.
REQ-030 reset_n pulsed low asynchronously between clock edges mid-digit-3: an=1111, sseg=FF immediately; after release, the full REQ-025 startup sequence repeats.
REQ-031 BLANK_CYCLES=0 variant: an never reads 1111 while en=1, and each digit is active for exactly 10 cycles.

Source files
------------

// File: rtl/sseg_mux.sv
// rtl/sseg_mux.sv - four-digit seven-segment scan multiplexer with frame-latched shadows
// Registered outputs follow counter/index state by one cycle; shadows update only at frame boundaries.
module sseg_mux #(
  parameter int unsigned REFRESH_MAX  = 49999,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic [7:0] dig_0,
  input  logic [7:0] dig_1,
  input  logic [7:0] dig_2,
  input  logic [7:0] dig_3,
  output logic [3:0] an,
  output logic [7:0] sseg,
  output logic       frame_start
);

  localparam logic [23:0] SLOT_LAST = 24'(REFRESH_MAX);
  localparam logic [23:0] BLANK_LEN = 24'(BLANK_CYCLES);

  logic [23:0] cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  shadow_q [4];
  logic        load_d;
  logic [3:0]  an_d;
  logic [7:0]  sseg_d;
  logic        frame_start_d;
  logic        slot_end_w;
  logic        blank_w;

  assign slot_end_w = (cnt_q == SLOT_LAST);

  generate
    if (BLANK_CYCLES == 0) begin : g_no_blank
      assign blank_w = 1'b0;
    end else begin : g_blank
      assign blank_w = (cnt_q < BLANK_LEN);
    end
  endgenerate

  // Disabled: counters parked at zero, outputs dark, shadows track inputs live.
  always_comb begin
    cnt_d         = 24'd0;
    idx_d         = 2'd0;
    load_d        = 1'b1;
    an_d          = 4'b1111;
    sseg_d        = 8'hFF;
    frame_start_d = 1'b0;
    if (en) begin
      cnt_d         = slot_end_w ? 24'd0 : cnt_q + 24'd1;
      idx_d         = slot_end_w ? idx_q + 2'd1 : idx_q;
      load_d        = slot_end_w && (idx_q == 2'd3);
      frame_start_d = (cnt_q == 24'd0) && (idx_q == 2'd0);
      if (!blank_w) begin
        an_d[idx_q] = 1'b0;
        sseg_d      = shadow_q[idx_q];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q       <= 24'd0;
      idx_q       <= 2'd0;
      for (int i = 0; i < 4; i++) shadow_q[i] <= 8'hFF;
      an          <= 4'b1111;
      sseg        <= 8'hFF;
      frame_start <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      if (load_d) begin
        shadow_q[0] <= dig_0;
        shadow_q[1] <= dig_1;
        shadow_q[2] <= dig_2;
        shadow_q[3] <= dig_3;
      end
      an          <= an_d;
      sseg        <= sseg_d;
      frame_start <= frame_start_d;
    end
  end

endmodule

// File: tb/tb_sseg_mux.sv
// tb/tb_sseg_mux.sv - directed bench for sseg_mux (REFRESH_MAX=9, blanking 2 and 0)
// Two instances share stimulus; one has blanking disabled.
module tb_sseg_mux;

  logic       clk;
  logic       reset_n;
  logic       en;
  logic [7:0] dig [4];
  logic [3:0] an_a, an_b;
  logic [7:0] sseg_a, sseg_b;
  logic       fs_a, fs_b;
  logic [7:0] exp_shadow [4];

  int checks;
  int errors;

  sseg_mux #(.REFRESH_MAX(9), .BLANK_CYCLES(2)) u_dut (
    .clk(clk), .reset_n(reset_n), .en(en),
    .dig_0(dig[0]), .dig_1(dig[1]), .dig_2(dig[2]), .dig_3(dig[3]),
    .an(an_a), .sseg(sseg_a), .frame_start(fs_a)
  );

  sseg_mux #(.REFRESH_MAX(9), .BLANK_CYCLES(0)) u_dut_nb (
    .clk(clk), .reset_n(reset_n), .en(en),
    .dig_0(dig[0]), .dig_1(dig[1]), .dig_2(dig[2]), .dig_3(dig[3]),
    .an(an_b), .sseg(sseg_b), .frame_start(fs_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic check_dark(input string tag);
    check({tag, "_an"}, {28'd0, an_a}, 32'hF);
    check({tag, "_sseg"}, {24'd0, sseg_a}, 32'hFF);
    check({tag, "_fs"}, {31'd0, fs_a}, 32'd0);
    check({tag, "_nb_an"}, {28'd0, an_b}, 32'hF);
    check({tag, "_nb_sseg"}, {24'd0, sseg_b}, 32'hFF);
    check({tag, "_nb_fs"}, {31'd0, fs_b}, 32'd0);
  endtask

  task automatic run_cycle(input int k);
    int slot;
    int dg;
    logic [3:0] e_an;
    logic [7:0] e_seg;
    logic       e_fs;
    @(posedge clk);
    #1;
    slot  = (k - 1) % 10;
    dg    = ((k - 1) / 10) % 4;
    e_fs  = (slot == 0) && (dg == 0);
    e_an  = 4'b1111;
    e_an[dg] = 1'b0;
    e_seg = exp_shadow[dg];
    check("nb_an", {28'd0, an_b}, {28'd0, e_an});
    check("nb_sseg", {24'd0, sseg_b}, {24'd0, e_seg});
    check("nb_fs", {31'd0, fs_b}, {31'd0, e_fs});
    if (slot < 2) begin
      e_an  = 4'b1111;
      e_seg = 8'hFF;
    end
    check("an", {28'd0, an_a}, {28'd0, e_an});
    check("sseg", {24'd0, sseg_a}, {24'd0, e_seg});
    check("fs", {31'd0, fs_a}, {31'd0, e_fs});
    if (k % 40 == 0) begin
      for (int i = 0; i < 4; i++) exp_shadow[i] = dig[i];
    end
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
    check_dark("idle");
    for (int i = 0; i < 4; i++) exp_shadow[i] = dig[i];
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset_n = 1'b1;
    en      = 1'b1;
    dig[0]  = 8'hC0;
    dig[1]  = 8'hF9;
    dig[2]  = 8'hA4;
    dig[3]  = 8'hB0;
    for (int i = 0; i < 4; i++) exp_shadow[i] = 8'hFF;

    #2 reset_n = 1'b0;
    #1 check_dark("reset");
    @(posedge clk);
    #1 check_dark("reset_hold");
    reset_n = 1'b1;

    // Startup, steady scan, and a mid-frame dig_1 change that must wait a frame.
    for (int k = 1; k <= 225; k++) begin
      run_cycle(k);
      if (k == 85) dig[1] = 8'h92;
    end

    // Drop enable inside the digit-2 slot.
    en = 1'b0;
    idle_cycle();
    dig[0] = 8'h99;
    for (int i = 0; i < 3; i++) idle_cycle();
    en = 1'b1;

    for (int k = 1; k <= 35; k++) run_cycle(k);

    // Asynchronous reset pulse between edges in the digit-3 slot.
    #2 reset_n = 1'b0;
    #1 check_dark("async_rst");
    for (int i = 0; i < 4; i++) exp_shadow[i] = 8'hFF;
    #1 reset_n = 1'b1;

    for (int k = 1; k <= 80; k++) run_cycle(k);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
